// File: rtl/fmeasure_multi.sv
// fmeasure_multi: frequency / event measurement block clocked by the clock
// under test.
//   mode 0 : counts clk cycles while the gate is high (one gate pulse).
//   mode 1 : counts gate rising edges inside a window of `window` cycles.
// Ports:
//   clk, rst_n (async, active-low)
//   gate, sync_select    gate input and optional 2-FF synchroniser select
//   mode, start, clear   measurement control (mode sampled on accepted start)
//   window               mode-1 window length, sampled on accepted start
//   div_select           divided-clock tap select
//   cycle_count          live counter
//   result/result_valid  latched result of last completed measurement
//   overflow             sticky saturation flag
//   busy                 measurement in progress
//   divided_clk          inverted counter bit 2*div_select+1
module fmeasure_multi #(
    parameter int LENGTH = 20,
    parameter int WIN_W  = 16,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate,
    input  logic              sync_select,
    input  logic              mode,
    input  logic              start,
    input  logic              clear,
    input  logic [WIN_W-1:0]  window,
    input  logic [SEL_W-1:0]  div_select,
    output logic [LENGTH-1:0] cycle_count,
    output logic [LENGTH-1:0] result,
    output logic              result_valid,
    output logic              overflow,
    output logic              busy,
    output logic              divided_clk
);

    typedef enum logic [1:0] {IDLE, WAIT_GATE, COUNT} state_t;

    state_t            state, state_n;
    logic [LENGTH-1:0] counter, counter_n, counter_inc, result_n;
    logic              valid_n, ovf_n, mode_r, mode_n;
    logic [WIN_W-1:0]  win_cnt, win_n;
    logic              sync1, sync2, gate_prev, gate_final, rise;
    logic              inc_req, sat;

    // Gate conditioning runs every cycle, independent of the FSM, so the
    // synchroniser and edge detector are already settled when a start lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            gate_prev <= 1'b0;
        end else begin
            sync1     <= gate;
            sync2     <= sync1;
            gate_prev <= gate_final;
        end
    end

    assign gate_final  = sync_select ? sync2 : gate;
    assign rise        = gate_final & ~gate_prev;

    // Saturating increment: at all-ones the counter holds and overflow is set.
    assign sat         = &counter;
    assign counter_inc = sat ? counter : counter + LENGTH'(1);

    always_comb begin
        state_n   = state;
        counter_n = counter;
        result_n  = result;
        valid_n   = result_valid;
        ovf_n     = overflow;
        win_n     = win_cnt;
        mode_n    = mode_r;
        inc_req   = 1'b0;
        if (clear) begin
            state_n   = IDLE;
            counter_n = '0;
            result_n  = '0;
            valid_n   = 1'b0;
            ovf_n     = 1'b0;
            win_n     = '0;
            mode_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        counter_n = '0;
                        ovf_n     = 1'b0;
                        valid_n   = 1'b0;
                        mode_n    = mode;
                        win_n     = window;
                        state_n   = mode ? COUNT : WAIT_GATE;
                    end
                end
                WAIT_GATE: begin
                    if (rise) begin
                        inc_req = 1'b1;
                        state_n = COUNT;
                    end
                end
                COUNT: begin
                    if (!mode_r) begin
                        if (gate_final) begin
                            inc_req = 1'b1;
                        end else begin
                            result_n = counter;
                            valid_n  = 1'b1;
                            state_n  = IDLE;
                        end
                    end else if (win_cnt == '0) begin
                        // Empty window: finish immediately with a zero result.
                        result_n = '0;
                        valid_n  = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        inc_req = rise;
                        win_n   = win_cnt - WIN_W'(1);
                        if (win_cnt == WIN_W'(1)) begin
                            // Last window cycle: include this cycle's edge.
                            result_n = rise ? counter_inc : counter;
                            valid_n  = 1'b1;
                            state_n  = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
            if (inc_req) begin
                counter_n = counter_inc;
                if (sat) ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            win_cnt      <= '0;
            mode_r       <= 1'b0;
        end else begin
            state        <= state_n;
            counter      <= counter_n;
            result       <= result_n;
            result_valid <= valid_n;
            overflow     <= ovf_n;
            win_cnt      <= win_n;
            mode_r       <= mode_n;
        end
    end

    assign cycle_count = counter;
    assign busy        = (state != IDLE);

    // Tap 2*div_select+1 gives divided periods of 4, 16, 64, 256 ... cycles.
    always_comb begin
        divided_clk = 1'b1;
        for (int i = 0; i < (1 << SEL_W); i++) begin
            if (div_select == SEL_W'(i)) divided_clk = ~counter[2*i+1];
        end
    end

endmodule

// File: tb/tb_fmeasure_multi.sv
// Scoreboard bench for fmeasure_multi: expected results are queued when a
// measurement is started; a monitor pops and compares on each result_valid
// rise. Directed checks cover reset, latency, overflow, clear and div taps.
module tb_fmeasure_multi;

    localparam int LENGTH = 20;
    localparam int WIN_W  = 16;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              gate = 1'b0, sync_select = 1'b0, mode = 1'b0;
    logic              start = 1'b0, clear = 1'b0;
    logic [WIN_W-1:0]  window = '0;
    logic [SEL_W-1:0]  div_select = '0;
    logic [LENGTH-1:0] cycle_count, result;
    logic              result_valid, overflow, busy, divided_clk;
    logic [7:0]        cycle_count_s, result_s;
    logic              result_valid_s, overflow_s, busy_s, divided_clk_s;

    always #5 clk = ~clk;

    fmeasure_multi #(.LENGTH(LENGTH), .WIN_W(WIN_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .gate(gate), .sync_select(sync_select),
        .mode(mode), .start(start), .clear(clear), .window(window),
        .div_select(div_select), .cycle_count(cycle_count), .result(result),
        .result_valid(result_valid), .overflow(overflow), .busy(busy),
        .divided_clk(divided_clk));

    // Narrow instance used for the saturation checks.
    fmeasure_multi #(.LENGTH(8), .WIN_W(WIN_W), .SEL_W(SEL_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .gate(gate), .sync_select(sync_select),
        .mode(mode), .start(start), .clear(clear), .window(window),
        .div_select(div_select), .cycle_count(cycle_count_s), .result(result_s),
        .result_valid(result_valid_s), .overflow(overflow_s), .busy(busy_s),
        .divided_clk(divided_clk_s));

    typedef struct { int res; int tol; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input int t);
        exp_t e;
        e.res = r;
        e.tol = t;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic m, input int w);
        start  = 1'b1;
        mode   = m;
        window = WIN_W'(w);
        tick(1);
        start  = 1'b0;
        mode   = 1'b0;
    endtask

    // Monitor: every new completed result is matched against the queue.
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && result_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d, expected no result", result);
            end else begin
                exp_t e;
                int   d;
                e = exp_q.pop_front();
                d = int'(result) - e.res;
                if (d < 0) d = -d;
                n_chk++;
                if (d > e.tol) begin
                    n_fail++;
                    $display("FAIL result: got %0d, expected %0d (+/-%0d)", result, e.res, e.tol);
                end
            end
        end
        rv_prev <= result_valid;
    end

    int prev_dc, n_half;

    initial begin
        // Reset state
        #3;
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_divided_clk", divided_clk, 1);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Mode 0, raw gate: 10-cycle gate pulse
        pulse_start(1'b0, 0);
        push(10, 0);
        gate = 1'b1;
        tick(10);
        gate = 1'b0;
        @(negedge clk);
        chk("m0_raw_valid_early", result_valid, 0);
        @(negedge clk);
        chk("m0_raw_valid_on_time", result_valid, 1);
        chk("m0_raw_busy_done", busy, 0);
        tick(3);

        // Mode 0, synchronised gate: same result, two cycles later
        sync_select = 1'b1;
        tick(3);
        pulse_start(1'b0, 0);
        push(10, 0);
        gate = 1'b1;
        tick(10);
        gate = 1'b0;
        repeat (3) @(negedge clk);
        chk("m0_sync_valid_early", result_valid, 0);
        @(negedge clk);
        chk("m0_sync_valid_on_time", result_valid, 1);
        tick(1);
        sync_select = 1'b0;
        tick(3);

        // Mode 1, window 100, gate period 10 cycles
        push(10, 1);
        for (int i = 0; i < 130; i++) begin
            start  = (i == 0);
            mode   = (i == 0);
            window = WIN_W'(100);
            gate   = ((i / 5) % 2) == 1;
            tick(1);
        end
        start = 1'b0;
        mode  = 1'b0;
        gate  = 1'b0;
        chk("m1_busy_done", busy, 0);
        tick(2);

        // Mode 1, empty window
        pulse_start(1'b1, 0);
        push(0, 0);
        chk("m1_w0_busy", busy, 1);
        tick(1);
        chk("m1_w0_idle", busy, 0);
        tick(2);

        // Saturation on the 8-bit instance; wide instance counts all 300
        pulse_start(1'b0, 0);
        push(300, 0);
        gate = 1'b1;
        tick(300);
        gate = 1'b0;
        tick(2);
        chk("sat_result", result_s, 255);
        chk("sat_overflow", overflow_s, 1);
        chk("sat_valid", result_valid_s, 1);
        chk("wide_no_overflow", overflow, 0);
        pulse_start(1'b1, 0);
        push(0, 0);
        chk("sat_overflow_cleared", overflow_s, 0);
        tick(3);

        // clear together with start mid-count
        pulse_start(1'b0, 0);
        gate = 1'b1;
        tick(5);
        chk("clr_busy_before", busy, 1);
        clear = 1'b1;
        start = 1'b1;
        tick(1);
        clear = 1'b0;
        start = 1'b0;
        chk("clr_cycle_count", cycle_count, 0);
        chk("clr_result", result, 0);
        chk("clr_result_valid", result_valid, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_busy", busy, 0);
        tick(2);
        chk("clr_stays_idle", busy, 0);
        gate = 1'b0;
        tick(2);

        // start while busy is ignored (mode/window change has no effect)
        pulse_start(1'b0, 0);
        push(6, 0);
        gate   = 1'b1;
        tick(3);
        start  = 1'b1;
        mode   = 1'b1;
        window = '0;
        tick(1);
        start  = 1'b0;
        mode   = 1'b0;
        tick(2);
        gate = 1'b0;
        tick(3);
        chk("busy_start_done", busy, 0);

        // divided_clk period sweep with gate held high
        pulse_start(1'b0, 0);
        gate = 1'b1;
        for (int d = 0; d < 4; d++) begin
            div_select = SEL_W'(d);
            @(negedge clk);
            prev_dc = divided_clk;
            for (int k = 0; k < 600; k++) begin
                @(negedge clk);
                if (divided_clk != prev_dc) break;
            end
            prev_dc = divided_clk;
            n_half  = 0;
            for (int k = 0; k < 600; k++) begin
                @(negedge clk);
                n_half++;
                if (divided_clk != prev_dc) break;
            end
            chk($sformatf("div_period_sel%0d", d), 2 * n_half, 4 ** (d + 1));
            tick(1);
        end

        // Asynchronous reset mid-count
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_divided_clk", divided_clk, 1);
        chk("arst_cycle_count", cycle_count, 0);
        chk("arst_result", result, 0);
        chk("arst_result_valid", result_valid, 0);
        chk("arst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        gate  = 1'b0;
        tick(3);
        chk("arst_no_result", result_valid, 0);
        chk("arst_idle_count", cycle_count, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
